// File: rtl/uart_rx_oversampled.sv
// UART receiver (start, DataBits data LSB first, one stop, no parity) driven by an
// oversampled tick. Each bit is resolved by a 3-sample majority vote around mid-bit.
// A low stop bit flags a framing error and parks the receiver until the line is high.
module uart_rx_oversampled #(
    parameter int unsigned Oversampling = 8,
    parameter int unsigned DataBits     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                rxd,
    output logic [DataBits-1:0] rx_data,
    output logic                rx_data_ready,
    output logic                rx_framing_err,
    output logic                rx_idle
);

    localparam int unsigned CW = (Oversampling > 1) ? $clog2(Oversampling) : 1;
    localparam int unsigned BW = (DataBits > 1) ? $clog2(DataBits) : 1;

    // Sample positions within a bit period; the decision tick is the last vote sample.
    localparam logic [CW-1:0] CntS0   = CW'(Oversampling / 2 - 1);
    localparam logic [CW-1:0] CntS1   = CW'(Oversampling / 2);
    localparam logic [CW-1:0] CntDec  = CW'(Oversampling / 2 + 1);
    localparam logic [CW-1:0] CntLast = CW'(Oversampling - 1);
    localparam logic [BW-1:0] IdxLast = BW'(DataBits - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state;
    logic                sync1;
    logic                rs;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bitidx;
    logic [DataBits-1:0] shift;
    logic                v0;
    logic                v1;
    logic                bit_val;

    logic                vote_c;
    logic                bit_now_c;
    logic [CW-1:0]       cnt_nxt_c;

    // Majority of the two earlier samples and the current synced line value.
    assign vote_c    = (v0 & v1) | (v0 & rs) | (v1 & rs);
    // With small oversampling the decision and end-of-bit ticks coincide; use the live vote then.
    assign bit_now_c = (cnt == CntDec) ? vote_c : bit_val;
    assign cnt_nxt_c = (cnt == CntLast) ? '0 : cnt + CW'(1);

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rs    <= 1'b1;
        end else begin
            sync1 <= rxd;
            rs    <= sync1;
        end
    end

    // Receive state machine; everything except the ready pulse advances only on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bitidx         <= '0;
            shift          <= '0;
            v0             <= 1'b0;
            v1             <= 1'b0;
            bit_val        <= 1'b0;
            rx_data        <= '0;
            rx_data_ready  <= 1'b0;
            rx_framing_err <= 1'b0;
            rx_idle        <= 1'b1;
        end else begin
            rx_data_ready <= 1'b0;
            if (tick) begin
                if (cnt == CntS0) v0 <= rs;
                if (cnt == CntS1) v1 <= rs;
                case (state)
                    IDLE: begin
                        // The detection tick is sample 0 of the start bit.
                        if (!rs) begin
                            state   <= START;
                            cnt     <= cnt_nxt_c;
                            rx_idle <= 1'b0;
                        end
                    end
                    START: begin
                        if (cnt == CntDec && vote_c) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            rx_idle <= 1'b1;
                        end else begin
                            cnt <= cnt_nxt_c;
                            if (cnt == CntLast) begin
                                state  <= DATA;
                                bitidx <= '0;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt == CntDec) bit_val <= vote_c;
                        cnt <= cnt_nxt_c;
                        if (cnt == CntLast) begin
                            shift <= (shift >> 1) | (DataBits'(bit_now_c) << (DataBits - 1));
                            if (bitidx == IdxLast) begin
                                state <= STOP;
                            end else begin
                                bitidx <= bitidx + BW'(1);
                            end
                        end
                    end
                    STOP: begin
                        if (cnt == CntDec) begin
                            cnt <= '0;
                            if (vote_c) begin
                                rx_data        <= shift;
                                rx_data_ready  <= 1'b1;
                                rx_framing_err <= 1'b0;
                                state          <= IDLE;
                                rx_idle        <= 1'b1;
                            end else begin
                                rx_framing_err <= 1'b1;
                                state          <= WAIT_HIGH;
                            end
                        end else begin
                            cnt <= cnt_nxt_c;
                        end
                    end
                    WAIT_HIGH: begin
                        // Hold off re-arming through a break or stuck-low line.
                        if (rs) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            rx_idle <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        rx_idle <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: a table of whole frames plus hand-written
// sequences for false start, framing error recovery and mid-frame reset.
module tb_uart_rx_oversampled;

    localparam int unsigned OS = 8;
    localparam int unsigned DB = 8;
    localparam int LATENCY = (1 + DB) * OS + OS / 2 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          rxd;
    logic [DB-1:0] rx_data;
    logic          rx_data_ready;
    logic          rx_framing_err;
    logic          rx_idle;

    always #5 clk = ~clk;

    uart_rx_oversampled #(
        .Oversampling(OS),
        .DataBits    (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_framing_err(rx_framing_err),
        .rx_idle       (rx_idle)
    );

    int n_vec = 0;
    int n_bad = 0;
    int tick_n = 0;
    int pulses = 0;
    int last_pulse_tick = -1;
    int start_tick = 0;
    int ready_cycles = 0;

    always @(negedge clk) if (rx_data_ready === 1'b1) ready_cycles++;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       flip;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One tick period: rxd set at a negedge, tick raised three clocks later for one clock.
    task automatic step(input logic r);
        rxd = r;
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        tick_n++;
        if (rx_data_ready === 1'b1) begin
            pulses++;
            last_pulse_tick = tick_n;
        end
    endtask

    // Whole frame; with flip set, one of the three vote samples of each data bit is inverted.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip);
        start_tick = tick_n + 1;
        for (int k = 0; k < OS; k++) step(1'b0);
        for (int b = 0; b < DB; b++)
            for (int k = 0; k < OS; k++)
                step((flip && k == 3 + (b % 3)) ? ~d[b] : d[b]);
        for (int k = 0; k < OS; k++) step(stop_bit);
    endtask

    initial begin
        int p0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 4, 8'hA5, 1'b0, 1};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 4, 8'hFF, 1'b0, 1};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 4, 8'hFF, 1'b0, 1};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 4, 8'h3C, 1'b0, 1};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 4, 8'h81, 1'b0, 1};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 4, 8'h81, 1'b1, 0};

        rst  = 1'b1;
        tick = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset rx_data", int'(rx_data), 0);
        check("reset ready", int'(rx_data_ready), 0);
        check("reset err", int'(rx_framing_err), 0);
        check("reset idle", int'(rx_idle), 1);
        for (int k = 0; k < 4; k++) step(1'b1);

        // Table of frames; vectors 2 and 3 are back to back with no idle gap.
        for (int i = 0; i < 7; i++) begin
            p0 = pulses;
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].flip);
            for (int k = 0; k < vecs[i].gap; k++) step(1'b1);
            check($sformatf("v%0d pulses", i), pulses - p0, vecs[i].exp_pulses);
            check($sformatf("v%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
            check($sformatf("v%0d err", i), int'(rx_framing_err), int'(vecs[i].exp_err));
            if (vecs[i].exp_pulses == 1)
                check($sformatf("v%0d latency", i), last_pulse_tick - start_tick, LATENCY);
            if (vecs[i].gap > 0)
                check($sformatf("v%0d idle", i), int'(rx_idle), 1);
        end

        // Reset in the middle of the data bits of 0x12; error flag is set beforehand.
        p0 = pulses;
        for (int k = 0; k < OS; k++) step(1'b0);
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < OS; k++) step(b == 1);
        rst = 1'b1;
        #1;
        check("midrst rx_data", int'(rx_data), 0);
        check("midrst err", int'(rx_framing_err), 0);
        check("midrst idle", int'(rx_idle), 1);
        check("midrst ready", int'(rx_data_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) step(1'b1);
        check("midrst no pulse", pulses - p0, 0);
        send_frame(8'h55, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1);
        check("after rst pulses", pulses - p0, 1);
        check("after rst rx_data", int'(rx_data), 8'h55);

        // Framing error, then line held low for 20 bit times.
        p0 = pulses;
        send_frame(8'h3C, 1'b0, 1'b0);
        for (int k = 0; k < 20 * OS; k++) step(1'b0);
        check("break err", int'(rx_framing_err), 1);
        check("break idle", int'(rx_idle), 0);
        check("break pulses", pulses - p0, 0);
        check("break rx_data", int'(rx_data), 8'h55);
        for (int k = 0; k < 4; k++) step(1'b1);
        check("rearm idle", int'(rx_idle), 1);
        check("rearm err held", int'(rx_framing_err), 1);
        send_frame(8'h3C, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1);
        check("recover pulses", pulses - p0, 1);
        check("recover rx_data", int'(rx_data), 8'h3C);
        check("recover err", int'(rx_framing_err), 0);

        // False start: two low ticks, aborted on the decision tick.
        p0 = pulses;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("false start busy", int'(rx_idle), 0);
        step(1'b1);
        check("false start idle", int'(rx_idle), 1);
        for (int k = 0; k < 10; k++) step(1'b1);
        check("false start pulses", pulses - p0, 0);
        check("false start rx_data", int'(rx_data), 8'h3C);

        // Tick frozen: line activity must not start a frame.
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        check("frozen idle", int'(rx_idle), 1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);

        check("ready width", ready_cycles, pulses);
        check("total pulses", pulses, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
